// File: rtl/shift_engine_pkg.sv
// Shared types and constants for the shift engine slice: FSM state encoding,
// transfer direction codes and the bit-counter width helper.
package shift_engine_pkg;

   typedef logic [0:0] stateT;

   localparam stateT IDLE  = 1'b0;
   localparam stateT SHIFT = 1'b1;

   localparam logic DIR_LSB = 1'b0;
   localparam logic DIR_MSB = 1'b1;

   // Counter width for a word of w bits; never zero so the vector stays legal.
   function automatic int unsigned cntWidth(input int unsigned w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

endpackage

// File: rtl/shift_engine_if.sv
// Bus between the shift engine and its controller: load/start/edge strobes in,
// serial/parallel data and handshake status out.
interface shift_engine_if #(
   parameter int unsigned WIDTH = 8
);

   logic             peripheralClkEdge;
   logic             parallelLoad;
   logic [WIDTH-1:0] parallelDataIn;
   logic             start;
   logic             msbFirst;
   logic             serialDataIn;
   logic             serialDataOut;
   logic [WIDTH-1:0] parallelDataOut;
   logic             busy;
   logic             done;
   logic             parityOut;

   modport master (
      output peripheralClkEdge,
      output parallelLoad,
      output parallelDataIn,
      output start,
      output msbFirst,
      output serialDataIn,
      input  serialDataOut,
      input  parallelDataOut,
      input  busy,
      input  done,
      input  parityOut
   );

   modport slave (
      input  peripheralClkEdge,
      input  parallelLoad,
      input  parallelDataIn,
      input  start,
      input  msbFirst,
      input  serialDataIn,
      output serialDataOut,
      output parallelDataOut,
      output busy,
      output done,
      output parityOut
   );

endinterface

// File: rtl/shift_bit_counter.sv
// Bit counter for one transfer: synchronous clear, increment, and a terminal
// flag raised while count == WIDTH-1. Wraps to zero on the terminal increment.
module shift_bit_counter
   import shift_engine_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   localparam int unsigned CntW = cntWidth(WIDTH)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            clear,
   input  logic            incr,
   output logic [CntW-1:0] count,
   output logic            terminal
);

   logic [CntW-1:0] countNext;

   assign terminal = (count == CntW'(WIDTH - 1));

   always_comb begin
      countNext = count;
      if (clear) begin
         countNext = '0;
      end else if (incr) begin
         countNext = terminal ? '0 : count + CntW'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else begin
         count <= countNext;
      end
   end

endmodule

// File: rtl/shift_engine.sv
// Transaction-based serial/parallel shift engine with start/busy/done handshake
// and runtime direction. Optional parity output enabled by SHIFT_ENGINE_PARITY_EN.
module shift_engine
   import shift_engine_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input logic           clk,
   input logic           reset,
   shift_engine_if.slave bus
);

   localparam int unsigned CntW = cntWidth(WIDTH);

   if (WIDTH < 2) begin : genWidthCheck
      $error("shift_engine: WIDTH must be at least 2");
   end

   logic [WIDTH-1:0] mem;
   stateT            state;
   logic             dirLatched;
   logic             doneReg;
   logic [CntW-1:0]  count;
   logic             terminal;
   logic             acceptStart;
   logic             doShift;
   logic             cntClear;

   // Load outranks start, which outranks a shift edge.
   always_comb begin
      acceptStart = !bus.parallelLoad && (state == IDLE) && bus.start;
      doShift     = !bus.parallelLoad && (state == SHIFT) && bus.peripheralClkEdge;
      cntClear    = bus.parallelLoad || acceptStart;
   end

   shift_bit_counter #(
      .WIDTH(WIDTH)
   ) uCounter (
      .clk     (clk),
      .reset   (reset),
      .clear   (cntClear),
      .incr    (doShift),
      .count   (count),
      .terminal(terminal)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem        <= '0;
         state      <= IDLE;
         dirLatched <= DIR_LSB;
         doneReg    <= 1'b0;
      end else begin
         doneReg <= 1'b0;
         if (bus.parallelLoad) begin
            mem   <= bus.parallelDataIn;
            state <= IDLE;
         end else if (acceptStart) begin
            state      <= SHIFT;
            dirLatched <= bus.msbFirst;
         end else if (doShift) begin
            if (dirLatched == DIR_MSB) begin
               mem <= {mem[WIDTH-2:0], bus.serialDataIn};
            end else begin
               mem <= {bus.serialDataIn, mem[WIDTH-1:1]};
            end
            if (terminal) begin
               state   <= IDLE;
               doneReg <= 1'b1;
            end
         end
      end
   end

   assign bus.serialDataOut   = (dirLatched == DIR_MSB) ? mem[WIDTH-1] : mem[0];
   assign bus.parallelDataOut = mem;
   assign bus.busy            = (state == SHIFT);
   assign bus.done            = doneReg;

`ifdef SHIFT_ENGINE_PARITY_EN
   assign bus.parityOut = ^mem;
`else
   assign bus.parityOut = 1'b0;
`endif

   aCountRange: assert property (@(posedge clk) disable iff (reset)
      count <= CntW'(WIDTH - 1));

   aDoneIdle: assert property (@(posedge clk) disable iff (reset)
      doneReg |-> (state == IDLE));

   aDonePulse: assert property (@(posedge clk) disable iff (reset)
      doneReg |=> !doneReg);

endmodule

// File: tb/tb_shift_engine.sv
// Scoreboard bench for shift_engine (WIDTH=8): stimulus queues expected serial
// bits and done-time words; a negedge monitor pops and compares them.
module tb_shift_engine;

   localparam int unsigned W = 8;

   logic clk = 1'b0;
   logic reset = 1'b1;

   always #5 clk = ~clk;

   shift_engine_if #(.WIDTH(W)) bus ();

   shift_engine #(
      .WIDTH(W)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   int checks = 0;
   int errors = 0;

   logic         serialQ[$];
   logic [W-1:0] doneQ[$];

   task automatic checkBit(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic checkWord(input string name, input logic [W-1:0] act,
                            input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: a real shift edge consumes one expected serial bit; done consumes one word.
   always @(negedge clk) begin
      if (!reset && bus.peripheralClkEdge && bus.busy && !bus.parallelLoad) begin
         if (serialQ.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL serial edge: got an edge in SHIFT, expected none (t=%0t)", $time);
         end else begin
            checkBit("serialDataOut", bus.serialDataOut, serialQ.pop_front());
         end
      end
      if (bus.done) begin
         if (doneQ.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL done pulse: got done=1, expected 0 (t=%0t)", $time);
         end else begin
            checkWord("done parallelDataOut", bus.parallelDataOut, doneQ.pop_front());
            checkBit("busy at done", bus.busy, 1'b0);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic doLoad(input logic [W-1:0] v);
      bus.parallelLoad   = 1'b1;
      bus.parallelDataIn = v;
      tick();
      bus.parallelLoad   = 1'b0;
   endtask

   task automatic doStart(input logic dir, input logic withEdge);
      bus.start             = 1'b1;
      bus.msbFirst          = dir;
      bus.peripheralClkEdge = withEdge;
      tick();
      bus.start             = 1'b0;
      bus.peripheralClkEdge = 1'b0;
   endtask

   task automatic doEdge(input logic sin);
      bus.peripheralClkEdge = 1'b1;
      bus.serialDataIn      = sin;
      tick();
      bus.peripheralClkEdge = 1'b0;
   endtask

   task automatic pushBits(input logic [W-1:0] bits, input int n);
      // bits[n-1] is expected first
      for (int i = n - 1; i >= 0; i--) serialQ.push_back(bits[i]);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
      $fatal(1);
   end

   initial begin
      bus.peripheralClkEdge = 1'b0;
      bus.parallelLoad      = 1'b0;
      bus.parallelDataIn    = '0;
      bus.start             = 1'b0;
      bus.msbFirst          = 1'b0;
      bus.serialDataIn      = 1'b0;

      // 1. Reset with clock running
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      tick();
      checkWord("reset parallelDataOut", bus.parallelDataOut, 8'h00);
      checkBit("reset busy", bus.busy, 1'b0);
      checkBit("reset done", bus.done, 1'b0);
      checkBit("reset serialDataOut", bus.serialDataOut, 1'b0);
      checkBit("reset parityOut", bus.parityOut, 1'b0);

      // 2. LSB first, shifting in ones
      doLoad(8'hC1);
      checkWord("load C1", bus.parallelDataOut, 8'hC1);
      doStart(1'b0, 1'b0);
      checkBit("busy after start", bus.busy, 1'b1);
      pushBits(8'b10000011, 8);
      doneQ.push_back(8'hFF);
      for (int i = 0; i < 8; i++) doEdge(1'b1);
      repeat (2) tick();
      checkBit("t2 busy end", bus.busy, 1'b0);
      checkBit("t2 done end", bus.done, 1'b0);

      // 3. MSB first, shifting in zeros
      doLoad(8'hC1);
      doStart(1'b1, 1'b0);
      checkBit("t3 busy", bus.busy, 1'b1);
      pushBits(8'b11000001, 8);
      doneQ.push_back(8'h00);
      for (int i = 0; i < 8; i++) doEdge(1'b0);
      repeat (2) tick();
      checkBit("t3 busy end", bus.busy, 1'b0);

      // 4. Abort by load after 3 edges, then a full transfer
      doLoad(8'h33);
      doStart(1'b0, 1'b0);
      pushBits(8'b00000110, 3);
      for (int i = 0; i < 3; i++) doEdge(1'b0);
      doLoad(8'h5A);
      tick();
      checkBit("t4 busy after abort", bus.busy, 1'b0);
      checkWord("t4 load 5A", bus.parallelDataOut, 8'h5A);
      checkBit("t4 done after abort", bus.done, 1'b0);
      doStart(1'b0, 1'b0);
      pushBits(8'b01011010, 8);
      doneQ.push_back(8'hFF);
      for (int i = 0; i < 7; i++) doEdge(1'b1);
      checkBit("t4 busy after 7", bus.busy, 1'b1);
      checkWord("t4 data after 7", bus.parallelDataOut, 8'hFE);
      doEdge(1'b1);
      repeat (2) tick();

      // 5. Edges in IDLE ignored; start with coincident edge does not shift
      doLoad(8'h81);
      doEdge(1'b1);
      doEdge(1'b1);
      checkWord("t5 idle edges", bus.parallelDataOut, 8'h81);
      doStart(1'b1, 1'b1);
      checkWord("t5 no shift on start", bus.parallelDataOut, 8'h81);
      checkBit("t5 busy", bus.busy, 1'b1);
      pushBits(8'b10000001, 8);
      doneQ.push_back(8'h00);
      for (int i = 0; i < 7; i++) doEdge(1'b0);
      checkBit("t5 busy after 7", bus.busy, 1'b1);
      doEdge(1'b0);
      repeat (2) tick();

      // 6. Async reset mid-transfer, between clock edges
      doLoad(8'hFF);
      doStart(1'b1, 1'b0);
      pushBits(8'b00001111, 4);
      for (int i = 0; i < 4; i++) doEdge(1'b1);
      checkBit("t6 serialDataOut before reset", bus.serialDataOut, 1'b1);
      #2 reset = 1'b1;
      #1;
      checkWord("t6 async parallelDataOut", bus.parallelDataOut, 8'h00);
      checkBit("t6 async busy", bus.busy, 1'b0);
      checkBit("t6 async serialDataOut", bus.serialDataOut, 1'b0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      repeat (3) tick();
      checkBit("t6 done after reset", bus.done, 1'b0);
      checkBit("t6 busy after reset", bus.busy, 1'b0);

      // Parity
      doLoad(8'h07);
`ifdef SHIFT_ENGINE_PARITY_EN
      checkBit("parity 07", bus.parityOut, 1'b1);
      doLoad(8'h03);
      checkBit("parity 03", bus.parityOut, 1'b0);
`else
      checkBit("parity disabled", bus.parityOut, 1'b0);
`endif

      repeat (3) tick();
      checkWord("serial queue drained", W'(serialQ.size()), 8'h00);
      checkWord("done queue drained", W'(doneQ.size()), 8'h00);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
